imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 125 ++++++++++++
 tb/tb_imem_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed fetch port with a fixed number of
// wait states, plus a program-load write port that is only serviced outside WAIT.
module imem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [29:0]       req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              load_ack
);

  localparam int DEPTH = 1 << ADDR_W;

  // The counter runs WAIT_CYCLES+1 down to 1 so that every fetch spends
  // WAIT_CYCLES+1 cycles before RESP, including the zero-wait case.
  localparam logic [4:0] CNT_LOAD = 5'(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [29:0] addr_lat;
  logic [31:0] mem [0:DEPTH-1];
  logic        accept;
  logic        load_do;
  logic        enter_resp;
  logic        addr_bad;
  logic [31:0] rd_word;

  function automatic logic out_of_range(input logic [29:0] a);
    return (a >> ADDR_W) != 30'd0;
  endfunction

  assign req_ready  = (state == IDLE || state == RESP) && !load_en;
  assign accept     = req_valid && req_ready;
  assign load_do    = load_en && (state == IDLE || state == RESP);
  assign resp_valid = (state == RESP);
  assign addr_bad   = out_of_range(addr_lat);
  assign rd_word    = mem[addr_lat[ADDR_W-1:0]];

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = WAIT;
          cnt_n   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == 5'd1) begin
          state_n    = RESP;
          cnt_n      = 5'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_n = cnt - 5'd1;
        end
      end
      RESP: begin
        if (accept) begin
          state_n = WAIT;
          cnt_n   = CNT_LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      load_ack <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      load_ack <= load_do;
    end
  end

  // Fetch address is only captured on acceptance, so req_addr may change freely afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_lat <= req_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
    end else if (enter_resp) begin
      resp_data <= addr_bad ? 32'd0 : rd_word;
      resp_err  <= addr_bad;
    end
  end

  // Array has no reset so a loaded program survives a CPU reset.
  always_ff @(posedge clk) begin
    if (load_do) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed table of fetches, multi-cycle corner sequences
// and a randomized load/fetch mix checked against a memory-array model.
module tb_imem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [29:0] req_addr = '0;
  logic        req_ready, resp_valid, resp_err, load_ack;
  logic [31:0] resp_data;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  logic        z_req_valid = 1'b0;
  logic [29:0] z_req_addr = '0;
  logic        z_req_ready, z_resp_valid, z_resp_err, z_load_ack;
  logic [31:0] z_resp_data;
  logic        z_load_en = 1'b0;
  logic [7:0]  z_load_addr = '0;
  logic [31:0] z_load_data = '0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] mref [0:255];

  imem_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_ack(load_ack)
  );

  imem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_addr(z_req_addr),
    .req_ready(z_req_ready), .resp_valid(z_resp_valid), .resp_data(z_resp_data),
    .resp_err(z_resp_err), .load_en(z_load_en), .load_addr(z_load_addr),
    .load_data(z_load_data), .load_ack(z_load_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [29:0] addr;
    logic [31:0] exp_data;
    logic        exp_err;
  } fvec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] a, input logic [31:0] d, output int lat);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (load_ack) begin
        lat = k;
        break;
      end
    end
    load_en = 1'b0;
    mref[a] = d;
  endtask

  task automatic load_check(input string nm, input logic [7:0] a, input logic [31:0] d);
    int lat;
    do_load(a, d, lat);
    check({nm, "_ack_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic wait_resp(output int lat, output logic [31:0] d, output logic e);
    lat = -1;
    d = '0;
    e = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (resp_valid) begin
        lat = k;
        d = resp_data;
        e = resp_err;
        break;
      end
      tick();
    end
  endtask

  task automatic do_fetch(input logic [29:0] a, output int lat, output logic [31:0] d,
                          output logic e);
    logic r;
    req_valid = 1'b1;
    req_addr = a;
    for (int k = 0; k < 40; k++) begin
      #1 r = req_ready;
      tick();
      if (r) break;
    end
    req_valid = 1'b0;
    req_addr = 30'($urandom);
    wait_resp(lat, d, e);
  endtask

  task automatic fetch_check(input string nm, input logic [29:0] a,
                             input logic [31:0] xd, input logic xe);
    int lat;
    logic [31:0] d;
    logic e;
    do_fetch(a, lat, d, e);
    check({nm, "_lat"}, 32'(lat), 32'(W + 1));
    check({nm, "_data"}, d, xd);
    check({nm, "_err"}, 32'(e), 32'(xe));
    tick();
    check({nm, "_pulse_end"}, 32'(resp_valid), 32'd0);
    check({nm, "_data_hold"}, resp_data, xd);
  endtask

  initial begin
    fvec_t tbl [0:6];
    int lat, ack_lat, rv_lat, ack_cnt, seen;
    logic [31:0] d, rv_data;
    logic e;
    logic [31:0] zv [0:2];
    int acc_cyc [0:3];
    int pls_cyc [0:3];
    logic [31:0] pls_dat [0:3];
    int na, np, idx;
    logic r;

    // ---- reset state ----
    #1 reset = 1'b1;
    #2;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_load_ack", 32'(load_ack), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // ---- basic load then fetch ----
    load_check("ld0", 8'h00, 32'h20080005);
    fetch_check("fetch0", 30'h0, 32'h20080005, 1'b0);

    // ---- directed table ----
    load_check("ld_ff", 8'hFF, 32'hDEADBEEF);
    load_check("ld_01", 8'h01, 32'h12345678);
    load_check("ld_80", 8'h80, 32'hA5A5A5A5);
    tbl[0] = '{30'h001, 32'h12345678, 1'b0};
    tbl[1] = '{30'h0FF, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{30'h080, 32'hA5A5A5A5, 1'b0};
    tbl[3] = '{30'h100, 32'h0, 1'b1};
    tbl[4] = '{30'h3FFFFFFF, 32'h0, 1'b1};
    tbl[5] = '{30'h20000000, 32'h0, 1'b1};
    tbl[6] = '{30'h000, 32'h20080005, 1'b0};
    for (int i = 0; i < 7; i++) begin
      fetch_check($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp_data, tbl[i].exp_err);
    end

    // ---- load and request together: load wins ----
    load_en = 1'b1; load_addr = 8'h10; load_data = 32'hC0FFEE39;
    req_valid = 1'b1; req_addr = 30'h10;
    #1 check("both_req_ready", 32'(req_ready), 32'd0);
    tick();
    check("both_load_ack", 32'(load_ack), 32'd1);
    check("both_no_resp", 32'(resp_valid), 32'd0);
    load_en = 1'b0;
    mref[8'h10] = 32'hC0FFEE39;
    #1 check("both_ready_after", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    wait_resp(lat, d, e);
    check("both_fetch_lat", 32'(lat), 32'(W + 1));
    check("both_fetch_data", d, 32'hC0FFEE39);
    tick();

    // ---- load_en held through WAIT ----
    load_check("ld_05", 8'h05, 32'h0BADF00D);
    req_valid = 1'b1; req_addr = 30'h5;
    #1 r = req_ready;
    tick();
    req_valid = 1'b0;
    load_en = 1'b1; load_addr = 8'h05; load_data = 32'h600DCAFE;
    ack_lat = -1; rv_lat = -1; ack_cnt = 0; rv_data = '0;
    for (int k = 0; k <= 12; k++) begin
      if (resp_valid) begin rv_lat = k; rv_data = resp_data; end
      if (load_ack) begin
        ack_cnt++;
        if (ack_lat < 0) ack_lat = k;
        load_en = 1'b0;
      end
      tick();
    end
    load_en = 1'b0;
    mref[8'h05] = 32'h600DCAFE;
    check("wldr_resp_lat", 32'(rv_lat), 32'(W + 1));
    check("wldr_old_data", rv_data, 32'h0BADF00D);
    check("wldr_ack_lat", 32'(ack_lat), 32'(W + 2));
    check("wldr_ack_cnt", 32'(ack_cnt), 32'd1);
    fetch_check("wldr_new", 30'h5, 32'h600DCAFE, 1'b0);

    // ---- reset mid-fetch ----
    req_valid = 1'b1; req_addr = 30'h0;
    #1 r = req_ready;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_data", resp_data, 32'd0);
    check("mid_rst_err", 32'(resp_err), 32'd0);
    check("mid_rst_ack", 32'(load_ack), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    load_en = 1'b1;
    #1 check("rst_ready_load", 32'(req_ready), 32'd0);
    load_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (resp_valid) seen++;
    end
    check("mid_rst_no_resp", 32'(seen), 32'd0);
    fetch_check("after_rst", 30'h0, 32'h20080005, 1'b0);

    // ---- zero wait states, back-to-back via RESP ----
    zv[0] = 32'h11110000; zv[1] = 32'h22221111; zv[2] = 32'h33332222;
    for (int i = 0; i < 3; i++) begin
      z_load_en = 1'b1; z_load_addr = 8'(i); z_load_data = zv[i];
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (z_load_ack) begin lat = k; break; end
      end
      z_load_en = 1'b0;
      check($sformatf("z_ld%0d_ack", i), 32'(lat), 32'd1);
    end
    tick();
    z_req_valid = 1'b1; z_req_addr = 30'h0;
    na = 0; np = 0; idx = 0;
    for (int k = 0; k < 16; k++) begin
      #1 r = z_req_ready && z_req_valid;
      tick();
      if (r) begin
        if (na < 4) acc_cyc[na] = cyc;
        na++;
        idx++;
        if (idx < 3) z_req_addr = 30'(idx);
        else z_req_valid = 1'b0;
      end
      if (z_resp_valid) begin
        if (np < 4) begin pls_cyc[np] = cyc; pls_dat[np] = z_resp_data; end
        np++;
      end
    end
    z_req_valid = 1'b0;
    check("z_accepts", 32'(na), 32'd3);
    check("z_pulses", 32'(np), 32'd3);
    if (na >= 1) begin
      for (int i = 0; i < 3 && i < np; i++) begin
        check($sformatf("z_pulse%0d_cyc", i), 32'(pls_cyc[i] - acc_cyc[0]), 32'(2 * i + 1));
        check($sformatf("z_pulse%0d_data", i), pls_dat[i], zv[i]);
      end
    end

    // ---- randomized mix against memory model ----
    for (int a = 0; a < 256; a++) begin
      do_load(8'(a), $urandom, lat);
      check("fill_ack", 32'(lat), 32'd1);
    end
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        load_check("rnd_ld", 8'($urandom_range(0, 255)), $urandom);
      end else begin
        logic [29:0] a;
        if ($urandom_range(0, 4) == 0) a = 30'($urandom) | 30'h100;
        else a = 30'($urandom_range(0, 255));
        if (a >= 30'd256) fetch_check("rnd_fetch", a, 32'h0, 1'b1);
        else fetch_check("rnd_fetch", a, mref[a[7:0]], 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
